// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned.
// Computes on operand magnitudes, then applies the result signs in a final fix-up cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StPrep = 3'd1;
    localparam logic [2:0] StIter = 3'd2;
    localparam logic [2:0] StFix  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] wquo_q, wquo_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   trial;

    // Shifted partial remainder minus divisor magnitude; MSB set means restore.
    assign trial = {prem_q, wquo_q[WIDTH-1]} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        prem_d  = prem_q;
        wquo_d  = wquo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i && !cancel_i) begin
                    state_d = StPrep;
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    sgn_d   = is_signed_i;
                end
            end
            StPrep: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    wquo_d  = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                    dvs_d   = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    q_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sgn_q & dvd_q[WIDTH-1];
                    prem_d  = '0;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = StIter;
                end
            end
            StIter: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    if (!trial[WIDTH]) begin
                        prem_d = trial[WIDTH-1:0];
                        wquo_d = {wquo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        prem_d = {prem_q[WIDTH-2:0], wquo_q[WIDTH-1]};
                        wquo_d = {wquo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StFix: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    // A zero divisor leaves the all-ones quotient unsigned-looking in both modes.
                    quo_d   = (q_neg_q && (dvs_q != '0)) ? -wquo_q : wquo_q;
                    rem_d   = r_neg_q ? -prem_q : prem_q;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            prem_q  <= '0;
            wquo_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            prem_q  <= prem_d;
            wquo_q  <= wquo_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o      = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
    assign done_o      = (state_q == StDone);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed/unsigned results, corner cases,
// ignored start, cancel and asynchronous reset behaviour.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sg = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .is_signed_i(sg),
        .cancel_i   (cancel),
        .dividend_i (a),
        .divisor_i  (b),
        .busy_o     (busy),
        .done_o     (done),
        .quotient_o (quo),
        .remainder_o(rem)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Cycle n is the interval after the n-th rising edge following start acceptance (edge 0).
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        sg    = s;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    task automatic div_check(input string tag, input logic s, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] eq,
                             input logic [31:0] er);
        int   n;
        logic bok;
        issue(s, x, y);
        n   = 0;
        bok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) bok = 1'b0;
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd34);
        chk({tag, " busy"}, {31'd0, bok}, 32'd1);
        chk({tag, " quo"}, quo, eq);
        chk({tag, " rem"}, rem, er);
        chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;

        repeat (2) @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst quo", quo, 32'd0);
        chk("rst rem", rem, 32'd0);
        rst_n = 1'b1;
        step();

        div_check("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        step();
        chk("done pulse", {31'd0, done}, 32'd0);
        chk("idle busy", {31'd0, busy}, 32'd0);

        // Back-to-back: each next start is issued in the DONE cycle.
        div_check("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_check("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        div_check("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        div_check("u 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        div_check("s -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        div_check("s -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        div_check("u max/16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);
        div_check("u min/2", 1'b0, 32'h8000_0000, 32'd2, 32'h4000_0000, 32'd0);
        div_check("s min/2", 1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0);
        div_check("s max/-1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0);
        div_check("u 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3);
        step();

        // Start while busy is ignored.
        issue(1'b0, 32'd100, 32'd7);
        n = 0;
        while (!done && n < 40) begin
            start = (n == 5);
            if (n == 5) begin
                a = 32'd9;
                b = 32'd3;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("ign latency", 32'(n), 32'd34);
        chk("ign quo", quo, 32'd14);
        chk("ign rem", rem, 32'd2);
        step();

        // Cancel mid-division.
        issue(1'b0, 32'd9, 32'd3);
        repeat (12) step();
        chk("cancel hold quo", quo, 32'd14);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            step();
        end
        chk("cancel no done", {31'd0, seen}, 32'd0);
        chk("cancel quo", quo, 32'd14);
        chk("cancel rem", rem, 32'd2);

        // Cancel beats start while idle.
        start  = 1'b1;
        cancel = 1'b1;
        a      = 32'd9;
        b      = 32'd3;
        step();
        start  = 1'b0;
        cancel = 1'b0;
        chk("cancel+start busy", {31'd0, busy}, 32'd0);
        step();
        chk("cancel+start done", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-division.
        issue(1'b0, 32'd50, 32'd5);
        repeat (20) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst quo", quo, 32'd0);
        chk("arst rem", rem, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        div_check("post-rst 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
